// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP32 multiplier issue block.
package fpu_pkg;

    // Issue sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } fsm_state_t;

    // Quiet NaN returned when the multiplier never answers
    localparam logic [31:0] FP32_QNAN = 32'hFFC00000;

    // Operand pair carried through the request FIFO
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } op_pair_t;

endpackage

// File: rtl/fpu_op_fifo.sv
// Request FIFO: wrapping read/write pointers plus an occupancy count.
// The head entry is presented combinationally so a pop can load it in the same cycle.
module fpu_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fpu_mul_issue.sv
// Issue sequencer between a request FIFO and a single-outstanding FP32 multiplier.
// Optional watchdog: define FPU_MUL_ISSUE_TIMEOUT_EN to return a QNaN error response
// when the multiplier does not answer within TIMEOUT cycles.
//
// state | meaning
// IDLE  | waiting for a queued request
// ISSUE | mul_valid pulse with held operands
// BUSY  | waiting for mul_ready (or watchdog expiry)
// RESP  | response held until rsp_ready; back-to-back pop on acceptance
module fpu_mul_issue
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      mul_din1,
    output logic [31:0]      mul_din2,
    output logic             mul_valid,
    input  logic [31:0]      mul_result,
    input  logic             mul_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    localparam int PW = 64 + TAG_W;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fsm_state_t       state_q, state_d;
    logic             rdy_en_q;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [PW-1:0]    fifo_rdata;
    op_pair_t         head_ops, hold_q;
    logic [TAG_W-1:0] head_tag, hold_tag_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_load, rsp_clear, to_hit, to_fire;

    // rdy_en_q keeps req_ready low through reset and raises it on the first edge after
    assign req_ready = rdy_en_q && (fifo_count != FULL_CNT);
    assign fifo_push = req_valid && rdy_en_q && !fifo_full;
    assign {head_ops, head_tag} = fifo_rdata;

    fpu_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({req_a, req_b, req_tag}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next-state and control decode; mul_ready is only honoured in BUSY
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        rsp_load  = 1'b0;
        rsp_clear = 1'b0;
        to_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = BUSY;
            BUSY: begin
                if (mul_ready) begin
                    rsp_load = 1'b1;
                    state_d  = RESP;
                end else if (to_hit) begin
                    rsp_load = 1'b1;
                    to_fire  = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_clear = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and ready enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Operand/tag holding registers; they drive the multiplier until the next pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q     <= '0;
            hold_tag_q <= '0;
        end else if (fifo_pop) begin
            hold_q     <= head_ops;
            hold_tag_q <= head_tag;
        end
    end

    // Response register; held stable until accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
        end else if (rsp_load) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= to_fire ? FP32_QNAN : mul_result;
            rsp_tag_q   <= hold_tag_q;
        end else if (rsp_clear) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef FPU_MUL_ISSUE_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT) + 1;
    // The count reaches TIMEOUT-1 on the edge that leaves this value
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 2);

    logic [TCW-1:0] to_cnt_q;
    logic           rsp_err_q;

    assign to_hit  = (to_cnt_q == TO_LAST);
    assign rsp_err = rsp_err_q;

    // Watchdog: cleared entering BUSY, counts every BUSY cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            to_cnt_q <= '0;
        end else if (state_q == BUSY) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Error flag travels with the response and clears on acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_err_q <= 1'b0;
        end else if (rsp_load) begin
            rsp_err_q <= to_fire;
        end else if (rsp_clear) begin
            rsp_err_q <= 1'b0;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign mul_valid = (state_q == ISSUE);
    assign mul_din1  = hold_q.a;
    assign mul_din2  = hold_q.b;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_fpu_mul_issue.sv
// Scoreboard bench for fpu_mul_issue with a behavioural multiplier model.
module tb_fpu_mul_issue;

    localparam int TAG_W = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] QNAN = 32'hFFC00000;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready;
    logic [31:0]      req_a, req_b;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      mul_din1, mul_din2, mul_result;
    logic             mul_valid, mul_ready;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    always #5 clk = ~clk;

    fpu_mul_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .mul_din1(mul_din1), .mul_din2(mul_din2), .mul_valid(mul_valid),
        .mul_result(mul_result), .mul_ready(mul_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
    typedef struct { logic [31:0] d; logic [TAG_W-1:0] t; logic e; } rsp_t;

    pair_t iss_q[$];
    rsp_t  exp_q[$];

    int pass_cnt = 0, chk_cnt = 0;
    int cyc = 0;
    int lat_n = 10;
    bit lat_rand = 0, never_mode = 0, spur_en = 0, rsp_rand = 0, saw_full = 0;
    bit m_busy = 0;
    int m_rem = 0;
    logic [31:0] m_a, m_b;
    int iss_cnt = 0, rsp_cnt = 0;
    int last_iss_cyc = 0, last_mrdy_cyc = 0, last_acc_cyc = 0, last_rise_cyc = 0;
    logic [31:0] last_rsp_data;
    logic [TAG_W-1:0] last_rsp_tag;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic bound_fail(input string name);
        chk_cnt++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Truncating IEEE single multiply for normal operands in a safe exponent range
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int e;
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    // Multiplier model: mul_ready N cycles after mul_valid, optional spurious pulses when idle
    initial begin
        mul_ready = 1'b0;
        mul_result = '0;
        forever begin
            @(posedge clk);
            #1;
            mul_ready = 1'b0;
            if (mul_valid) begin
                iss_cnt++;
                last_iss_cyc = cyc;
                if (iss_q.size() == 0) begin
                    bound_fail("issue_unexpected");
                end else begin
                    pair_t p;
                    p = iss_q.pop_front();
                    check("issue_din1", mul_din1, p.a);
                    check("issue_din2", mul_din2, p.b);
                end
            end
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    mul_ready = 1'b1;
                    mul_result = fmul(m_a, m_b);
                    m_busy = 0;
                    last_mrdy_cyc = cyc;
                end
            end else if (mul_valid) begin
                m_a = mul_din1;
                m_b = mul_din2;
                if (!never_mode) begin
                    m_busy = 1;
                    m_rem = lat_rand ? int'($urandom_range(1, 6)) : lat_n;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                mul_ready = 1'b1;
                mul_result = $urandom;
            end
        end
    end

    // Random consumer back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rsp_rand) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: records accepted requests, compares responses, checks hold stability
    initial begin
        bit prev_hold = 0, prev_rv = 0;
        logic [31:0] hold_d;
        logic [TAG_W-1:0] hold_t;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (req_valid && req_ready) begin
                    pair_t p;
                    rsp_t r;
                    p.a = req_a;
                    p.b = req_b;
                    iss_q.push_back(p);
                    r.d = never_mode ? QNAN : fmul(req_a, req_b);
                    r.t = req_tag;
                    r.e = never_mode;
                    exp_q.push_back(r);
                    last_acc_cyc = cyc;
                end
                if (req_valid && !req_ready) saw_full = 1;
                if (rsp_valid && !prev_rv) last_rise_cyc = cyc;
                if (prev_hold) begin
                    check("hold_data", rsp_data, hold_d);
                    check("hold_tag", 32'(rsp_tag), 32'(hold_t));
                end
                if (rsp_valid && rsp_ready) begin
                    rsp_cnt++;
                    last_rsp_data = rsp_data;
                    last_rsp_tag = rsp_tag;
                    if (exp_q.size() == 0) begin
                        bound_fail("rsp_unexpected");
                    end else begin
                        rsp_t r;
                        r = exp_q.pop_front();
                        check("rsp_data", rsp_data, r.d);
                        check("rsp_tag", 32'(rsp_tag), 32'(r.t));
                        check("rsp_err", 32'(rsp_err), 32'(r.e));
                    end
                end
                prev_hold = rsp_valid && !rsp_ready;
                hold_d = rsp_data;
                hold_t = rsp_tag;
                prev_rv = rsp_valid;
            end else begin
                prev_hold = 0;
                prev_rv = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        bit ok;
        int n;
        n = 0;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_tag = t;
        do begin
            @(negedge clk);
            ok = req_ready;
            tick();
            n++;
        end while (!ok && n < 300);
        req_valid = 1'b0;
        if (!ok) bound_fail("send");
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n;
        n = 0;
        while (rsp_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (rsp_cnt < target) bound_fail("wait_rsp");
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"}, 32'(req_ready), 0);
        check({pfx, "_mul_valid"}, 32'(mul_valid), 0);
        check({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({pfx, "_rsp_err"}, 32'(rsp_err), 0);
        check({pfx, "_mul_din1"}, mul_din1, 0);
        check({pfx, "_mul_din2"}, mul_din2, 0);
        check({pfx, "_rsp_data"}, rsp_data, 0);
        check({pfx, "_rsp_tag"}, 32'(rsp_tag), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation bound reached");
        $fatal(1);
    end

    initial begin
        int base, rbase, acc_cyc, n;
        reset = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_tag = '0;
        rsp_ready = 1'b0;

        // Reset values and ready release timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("ready_before_edge", 32'(req_ready), 0);
        @(negedge clk);
        check("ready_first_edge", 32'(req_ready), 1);
        tick();

        // Single 3.0 * 2.0 request, N=10
        rsp_ready = 1'b1;
        lat_n = 10;
        base = iss_cnt;
        rbase = rsp_cnt;
        send(32'h40400000, 32'h40000000, 4'd3);
        wait_rsp(rbase + 1, 200);
        check("t1_issues", 32'(iss_cnt - base), 1);
        check("t1_issue_lat", 32'(last_iss_cyc - last_acc_cyc), 2);
        check("t1_rsp_lat", 32'(last_rise_cyc - last_mrdy_cyc), 1);
        check("t1_data", last_rsp_data, 32'h40C00000);
        check("t1_tag", 32'(last_rsp_tag), 3);

        // Burst of 6 into a 4-deep FIFO
        lat_n = 8;
        saw_full = 0;
        base = iss_cnt;
        rbase = rsp_cnt;
        for (int t = 0; t < 6; t++) send(rand_fp(), rand_fp(), 4'(t));
        wait_rsp(rbase + 6, 500);
        check("t2_saw_full", 32'(saw_full), 1);
        check("t2_issues", 32'(iss_cnt - base), 6);
        check("t2_rsps", 32'(rsp_cnt - rbase), 6);

        // Back-pressure with two queued requests
        rsp_ready = 1'b0;
        lat_n = 3;
        rbase = rsp_cnt;
        send(rand_fp(), rand_fp(), 4'd7);
        send(rand_fp(), rand_fp(), 4'd8);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        if (!rsp_valid) bound_fail("t3_first_rsp");
        base = iss_cnt;
        repeat (20) tick();
        check("t3_rsp_held", 32'(rsp_valid), 1);
        check("t3_no_second_issue", 32'(iss_cnt - base), 0);
        rsp_ready = 1'b1;
        acc_cyc = cyc;
        wait_rsp(rbase + 2, 100);
        check("t3_second_issue", 32'(iss_cnt - base), 1);
        check("t3_reissue_cycle", 32'(last_iss_cyc - acc_cyc), 1);

        // Randomised traffic with spurious mul_ready and random back-pressure
        lat_rand = 1;
        spur_en = 1;
        rsp_rand = 1;
        base = iss_cnt;
        rbase = rsp_cnt;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send(rand_fp(), rand_fp(), 4'(i));
        end
        wait_rsp(rbase + 30, 2000);
        rsp_rand = 0;
        spur_en = 0;
        lat_rand = 0;
        rsp_ready = 1'b1;
        check("t4_issues", 32'(iss_cnt - base), 30);
        repeat (10) tick();
        check("t4_no_extra_rsp", 32'(rsp_cnt - rbase), 30);

        // Reset while BUSY with requests queued; stale mul_ready after release
        lat_n = 15;
        for (int t = 9; t < 13; t++) send(rand_fp(), rand_fp(), 4'(t));
        repeat (2) tick();
        check("t5_model_busy", 32'(m_busy), 1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        iss_q.delete();
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        base = iss_cnt;
        rbase = rsp_cnt;
        repeat (30) tick();
        check("t5_stale_consumed", 32'(m_busy), 0);
        check("t5_no_issue", 32'(iss_cnt - base), 0);
        check("t5_no_rsp", 32'(rsp_cnt - rbase), 0);
        check("t5_rsp_valid", 32'(rsp_valid), 0);
        check("t5_req_ready", 32'(req_ready), 1);

`ifdef FPU_MUL_ISSUE_TIMEOUT_EN
        // Watchdog: multiplier never answers
        never_mode = 1;
        rbase = rsp_cnt;
        send(rand_fp(), rand_fp(), 4'd5);
        wait_rsp(rbase + 1, 200);
        check("t6_timeout_lat", 32'(last_rise_cyc - last_iss_cyc), 32);
        check("t6_data", last_rsp_data, QNAN);
        @(negedge clk);
        check("t6_err_cleared", 32'(rsp_err), 0);
        tick();
        never_mode = 0;
`endif

        // Normal operation after everything above
        lat_n = 2;
        rbase = rsp_cnt;
        send(32'h3F800000, 32'h40800000, 4'd14);
        wait_rsp(rbase + 1, 100);
        check("t7_data", last_rsp_data, 32'h40800000);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
